sync_key_switch: RTL



---
 rtl/sync_key_pkg.sv | 20 ++
 rtl/sync_key_switch_matcher.sv | 56 +++++
 rtl/sync_key_switch.sv | 115 +++++++++++
 3 files changed

// File: rtl/sync_key_pkg.sv
// Shared types and defaults for the sync-triggered key-stream switch.
package sync_key_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        KEY  = 1'b1
    } key_state_t;

    localparam int          DEF_W        = 2;
    localparam int          DEF_SYNC_LEN = 2;
    localparam logic [3:0]  DEF_SYNC_PAT = {2'b01, 2'b00};
    localparam int          DEF_KEY_LEN  = 3;
    localparam int          DEF_CNT_W    = 8;

    // Width of the sync match index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return $clog2((n < 2) ? 2 : n);
    endfunction

endpackage

// File: rtl/sync_key_switch_matcher.sv
// In-order sync sequence matcher with a simple restart on mismatch.
module sync_matcher
    import sync_key_pkg::*;
#(
    parameter int                      W        = DEF_W,
    parameter int                      SYNC_LEN = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN*W-1:0]   SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         in_valid,
    input  logic [W-1:0] in,
    output logic         hit
);

    localparam int                IDX_W    = idx_width(SYNC_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SYNC_LEN - 1);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic [W-1:0]     expect_sym;
    logic [W-1:0]     first_sym;
    logic             sym_match;
    logic             advance;

    // Compare the current symbol against the expected one and work out the next index.
    always_comb begin
        expect_sym = SYNC_PAT[32'(idx) * W +: W];
        first_sym  = SYNC_PAT[W-1:0];
        sym_match  = (in == expect_sym);
        advance    = in_valid && enable && !clear;
        hit        = advance && sym_match && (idx == LAST_IDX);
        idx_d      = idx;
        if (clear) begin
            idx_d = '0;
        end else if (advance) begin
            if (sym_match) begin
                idx_d = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                idx_d = (in == first_sym) ? IDX_W'(1) : '0;
            end
        end
    end

    // Match index register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else begin
            idx <= idx_d;
        end
    end

endmodule

// File: rtl/sync_key_switch.sv
// Output-stage selector: passes data until the sync sequence is seen, then
// substitutes key-stream symbols for a bounded number of valid cycles.
module sync_key_switch
    import sync_key_pkg::*;
#(
    parameter int                      W        = DEF_W,
    parameter int                      SYNC_LEN = DEF_SYNC_LEN,
    parameter logic [SYNC_LEN*W-1:0]   SYNC_PAT = DEF_SYNC_PAT,
    parameter int                      KEY_LEN  = DEF_KEY_LEN,
    parameter int                      CNT_W    = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [W-1:0]     in,
    input  logic [W-1:0]     kin,
    output logic             out_valid,
    output logic [W-1:0]     out,
    output logic             key_active,
    output logic             sync_hit,
    output logic [CNT_W-1:0] key_cnt
);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'((KEY_LEN == 0) ? 0 : KEY_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    key_state_t       state_q;
    key_state_t       state_d;
    logic             hit;
    logic [CNT_W-1:0] cnt_d;
    logic [W-1:0]     out_d;
    logic             out_valid_d;
    logic             sync_hit_d;

    sync_matcher #(
        .W        (W),
        .SYNC_LEN (SYNC_LEN),
        .SYNC_PAT (SYNC_PAT)
    ) u_matcher (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .enable   (state_q == HUNT),
        .in_valid (in_valid),
        .in       (in),
        .hit      (hit)
    );

    // Next state and next output values; clear wins over normal operation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = key_cnt;
        out_d       = out;
        out_valid_d = in_valid;
        sync_hit_d  = 1'b0;
        if (clear) begin
            state_d     = HUNT;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                HUNT: begin
                    out_d = in;
                    if (hit) begin
                        state_d    = KEY;
                        cnt_d      = '0;
                        sync_hit_d = 1'b1;
                    end
                end
                KEY: begin
                    out_d = kin;
                    if ((KEY_LEN != 0) && (key_cnt == KEY_LAST)) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else if ((KEY_LEN == 0) && (key_cnt == CNT_MAX)) begin
                        cnt_d = key_cnt;
                    end else begin
                        cnt_d = key_cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs and key counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            sync_hit  <= 1'b0;
            key_cnt   <= '0;
        end else begin
            out       <= out_d;
            out_valid <= out_valid_d;
            sync_hit  <= sync_hit_d;
            key_cnt   <= cnt_d;
        end
    end

    assign key_active = (state_q == KEY);

endmodule
